// File: rtl/ov7670_pixel_assembler_if.sv
// Pixel stream from the OV7670 assembler to the convolution engine:
// head pixel, its coordinates and frame/line markers, plus the consumer's take pulse.
interface ov7670_pixel_assembler_if;
   logic        colour_load_comp;
   logic [23:0] colour_data;
   logic        colour_ready;
   logic [8:0]  pix_x;
   logic [7:0]  pix_y;
   logic        frame_start;
   logic        line_end;

   modport master (
      input  colour_load_comp,
      output colour_data,
      output colour_ready,
      output pix_x,
      output pix_y,
      output frame_start,
      output line_end
   );

   modport slave (
      output colour_load_comp,
      input  colour_data,
      input  colour_ready,
      input  pix_x,
      input  pix_y,
      input  frame_start,
      input  line_end
   );
endinterface

// File: rtl/ov7670_pixel_assembler.sv
// Oversamples the OV7670 camera bus in the clk_50M domain, pairs bytes into RGB565,
// expands to RGB888 and queues tagged pixels in a small first-word-fall-through FIFO.
module ov7670_pixel_assembler #(
   parameter int H_PIXELS   = 320,
   parameter int V_LINES    = 240,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk_50M,
   input  logic                          rst,
   input  logic                          PCLK,
   input  logic                          VS,
   input  logic                          HS,
   input  logic [7:0]                    OV7670_In_data,
   input  logic                          Init_Comp,
   ov7670_pixel_assembler_if.master      pix_bus,
   output logic                          overflow
);

   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = 24 + 9 + 8 + 2;
   localparam int N_CTL   = 3;

   localparam logic [8:0]  X_LAST    = 9'(H_PIXELS - 1);
   localparam logic [7:0]  Y_LAST    = 8'(V_LINES - 1);
   localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
   localparam logic [1:0] ST_LINE       = 2'd2;
   localparam logic [1:0] ST_BLANK      = 2'd3;

   // Control pins: bit 2 = PCLK, bit 1 = VS, bit 0 = HS. Third stage feeds edge detection.
   logic [N_CTL-1:0] ctl_pins;
   logic [N_CTL-1:0] ctl_s2;
   logic [N_CTL-1:0] ctl_s3;

   assign ctl_pins = {PCLK, VS, HS};

   generate
      for (genvar gi = 0; gi < N_CTL; gi++) begin : g_ctl_sync
         logic [2:0] chain_reg;
         always_ff @(posedge clk_50M or negedge rst) begin
            if (!rst) begin
               chain_reg <= 3'b000;
            end else begin
               chain_reg <= {chain_reg[1:0], ctl_pins[gi]};
            end
         end
         assign ctl_s2[gi] = chain_reg[1];
         assign ctl_s3[gi] = chain_reg[2];
      end
   endgenerate

   // Data takes the same two stages as PCLK so it is sampled alongside the strobe.
   logic [7:0] d_s1_reg;
   logic [7:0] d_s2_reg;

   always_ff @(posedge clk_50M or negedge rst) begin
      if (!rst) begin
         d_s1_reg <= 8'h00;
         d_s2_reg <= 8'h00;
      end else begin
         d_s1_reg <= OV7670_In_data;
         d_s2_reg <= d_s1_reg;
      end
   end

   logic pclk_rise;
   logic vs_rise;
   logic vs_fall;
   logic hs_s2;
   logic hs_rise;
   logic hs_fall;

   assign pclk_rise = ctl_s2[2] & ~ctl_s3[2];
   assign vs_rise   = ctl_s2[1] & ~ctl_s3[1];
   assign vs_fall   = ~ctl_s2[1] & ctl_s3[1];
   assign hs_s2     = ctl_s2[0];
   assign hs_rise   = ctl_s2[0] & ~ctl_s3[0];
   assign hs_fall   = ~ctl_s2[0] & ctl_s3[0];

   logic [1:0] state_reg,   state_next;
   logic       phase_reg,   phase_next;
   logic [7:0] hi_byte_reg, hi_byte_next;
   logic [8:0] x_reg,       x_next;
   logic [7:0] y_reg,       y_next;
   logic       push;

   always_comb begin
      state_next   = state_reg;
      phase_next   = phase_reg;
      hi_byte_next = hi_byte_reg;
      x_next       = x_reg;
      y_next       = y_reg;
      push         = 1'b0;
      if (!Init_Comp) begin
         state_next = ST_IDLE;
         phase_next = 1'b0;
      end else if (state_reg != ST_IDLE && vs_rise) begin
         // New vertical blank: any partial line is abandoned.
         state_next = ST_WAIT_FRAME;
         phase_next = 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               state_next = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
               if (vs_fall) begin
                  y_next     = 8'd0;
                  state_next = ST_BLANK;
               end
            end
            ST_BLANK: begin
               phase_next = 1'b0;
               if (hs_rise) begin
                  x_next     = 9'd0;
                  state_next = ST_LINE;
               end
            end
            ST_LINE: begin
               if (hs_fall) begin
                  // A pending high byte is simply forgotten here.
                  state_next = ST_BLANK;
                  phase_next = 1'b0;
                  if (y_reg != Y_LAST) begin
                     y_next = y_reg + 8'd1;
                  end
               end else if (pclk_rise && hs_s2) begin
                  phase_next = ~phase_reg;
                  if (!phase_reg) begin
                     hi_byte_next = d_s2_reg;
                  end else begin
                     push   = 1'b1;
                     x_next = (x_reg == X_LAST) ? 9'd0 : x_reg + 9'd1;
                  end
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_50M or negedge rst) begin
      if (!rst) begin
         state_reg   <= ST_IDLE;
         phase_reg   <= 1'b0;
         hi_byte_reg <= 8'h00;
         x_reg       <= 9'd0;
         y_reg       <= 8'd0;
      end else begin
         state_reg   <= state_next;
         phase_reg   <= phase_next;
         hi_byte_reg <= hi_byte_next;
         x_reg       <= x_next;
         y_reg       <= y_next;
      end
   end

   // RGB565 -> RGB888 by replicating the top bits into the new LSBs.
   logic [15:0]        rgb565;
   logic [23:0]        rgb888;
   logic [ENTRY_W-1:0] push_entry;

   assign rgb565     = {hi_byte_reg, d_s2_reg};
   assign rgb888     = {rgb565[15:11], rgb565[15:13],
                        rgb565[10:5],  rgb565[10:9],
                        rgb565[4:0],   rgb565[4:2]};
   assign push_entry = {rgb888, x_reg, y_reg,
                        (x_reg == 9'd0) && (y_reg == 8'd0),
                        (x_reg == X_LAST)};

   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr_reg;
   logic [AW-1:0]      rd_ptr_reg;
   logic [AW-1:0]      rd_ptr_next;
   logic [AW:0]        count_reg;
   logic [AW:0]        count_next;
   logic [AW:0]        remain;
   logic               pop_ok;
   logic               push_ok;
   logic [ENTRY_W-1:0] head_reg;
   logic [ENTRY_W-1:0] head_next;
   logic               ready_reg;

   assign pop_ok  = pix_bus.colour_load_comp && (count_reg != '0);
   assign push_ok = push && ((count_reg != DEPTH_CNT) || pop_ok);

   // Head register holds whatever will sit at the front after this cycle's pop/push.
   always_comb begin
      remain      = count_reg - (AW + 1)'(pop_ok);
      count_next  = remain + (AW + 1)'(push_ok);
      rd_ptr_next = rd_ptr_reg + AW'(pop_ok);
      head_next   = '0;
      if (count_next != '0) begin
         if (remain == '0) begin
            head_next = push_entry;
         end else begin
            head_next = mem[rd_ptr_next];
         end
      end
   end

   always_ff @(posedge clk_50M) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_entry;
      end
   end

   always_ff @(posedge clk_50M or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= '0;
         ready_reg  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         head_reg   <= head_next;
         ready_reg  <= (count_next != '0);
         if (push && !push_ok) begin
            overflow <= 1'b1;
         end else if (vs_rise) begin
            overflow <= 1'b0;
         end
      end
   end

   assign pix_bus.colour_data  = head_reg[42:19];
   assign pix_bus.pix_x        = head_reg[18:10];
   assign pix_bus.pix_y        = head_reg[9:2];
   assign pix_bus.frame_start  = head_reg[1];
   assign pix_bus.line_end     = head_reg[0];
   assign pix_bus.colour_ready = ready_reg;

endmodule
